// File: rtl/digit_scan8.sv
// Eight-digit display scanner: free-running digit index with a programmable slot
// length, plus a double-buffered value that only changes at frame boundaries.
module digit_scan8 #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        active,
  output logic        tick,
  output logic        frame_done
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [31:0]   disp_q, disp_d;
  logic          tick_q, tick_d;
  logic          fd_q, fd_d;
  logic          step, commit;

  always_comb begin
    step      = (pcnt_q == PMAX);
    commit    = step && (sel_q == 3'd7);
    pcnt_d    = step ? '0 : pcnt_q + PW'(1);
    sel_d     = step ? sel_q + 3'd1 : sel_q;
    shadow_d  = load ? value : shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (commit) begin
      // A load landing on the commit edge bypasses the shadow so it shows immediately.
      pending_d = 1'b0;
      if (load)           disp_d = value;
      else if (pending_q) disp_d = shadow_q;
    end else if (load) begin
      pending_d = 1'b1;
    end
    tick_d = step;
    fd_d   = commit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q    <= '0;
      sel_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      disp_q    <= '0;
      tick_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      tick_q    <= tick_d;
      fd_q      <= fd_d;
    end
  end

  assign sel        = sel_q;
  assign nibble     = disp_q[{sel_q, 2'b00} +: 4];
  assign active     = digit_en[sel_q];
  assign tick       = tick_q;
  assign frame_done = fd_q;
endmodule
